// File: rtl/demod_decim.sv
// Four-channel interleaved integrate-and-dump decimator with a single AXI-Stream output register.
// Define DEMOD_DECIM_ROUND_EN to round half up before the divide; otherwise the divide floors.
module demod_decim #(
   parameter int DECIM_LOG2 = 5
) (
   input  logic        s_axis_aclk,
   input  logic        s_axis_aresetn,
   input  logic [23:0] s_axis_tdata,
   input  logic        s_axis_tvalid,
   output logic        s_axis_tready,
   input  logic [1:0]  s_axis_tuser,
   output logic [23:0] m_axis_tdata,
   output logic        m_axis_tvalid,
   input  logic        m_axis_tready,
   output logic [1:0]  m_axis_tuser
);

   localparam int AW = 24 + DECIM_LOG2 + 1;
   localparam logic [DECIM_LOG2-1:0] CNT_MAX = '1;

   logic signed [AW-1:0]   r_acc [4];
   logic [DECIM_LOG2-1:0]  r_cnt [4];
   logic                   r_m_valid;
   logic [23:0]            r_m_data;
   logic [1:0]             r_m_user;

   logic                   w_accept;
   logic                   w_dump;
   logic signed [AW-1:0]   w_sext;
   logic signed [AW-1:0]   w_sum;
   logic signed [AW-1:0]   w_sum_adj;
   logic [23:0]            w_avg;

   // A held output blocks the input so no beat is accepted that could need a second slot.
   assign s_axis_tready = !r_m_valid | m_axis_tready;
   assign w_accept      = s_axis_tvalid & s_axis_tready;

   assign w_sext = {{(AW-24){s_axis_tdata[23]}}, s_axis_tdata};
   assign w_sum  = r_acc[s_axis_tuser] + w_sext;
   assign w_dump = w_accept && (r_cnt[s_axis_tuser] == CNT_MAX);

`ifdef DEMOD_DECIM_ROUND_EN
   localparam logic signed [AW-1:0] RND = AW'(2 ** (DECIM_LOG2 - 1));
   assign w_sum_adj = w_sum + RND;
`else
   assign w_sum_adj = w_sum;
`endif

   // The divided sum always fits 24 bits, so truncation loses nothing.
   assign w_avg = 24'(w_sum_adj >>> DECIM_LOG2);

   always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
      if (!s_axis_aresetn) begin
         for (int c = 0; c < 4; c++) begin
            r_acc[c] <= '0;
            r_cnt[c] <= '0;
         end
      end else begin
         for (int c = 0; c < 4; c++) begin
            if (w_accept && (s_axis_tuser == 2'(c))) begin
               if (r_cnt[c] == CNT_MAX) begin
                  r_acc[c] <= '0;
                  r_cnt[c] <= '0;
               end else begin
                  r_acc[c] <= w_sum;
                  r_cnt[c] <= r_cnt[c] + DECIM_LOG2'(1);
               end
            end
         end
      end
   end

   always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
      if (!s_axis_aresetn) begin
         r_m_valid <= 1'b0;
         r_m_data  <= '0;
         r_m_user  <= '0;
      end else if (w_dump) begin
         r_m_valid <= 1'b1;
         r_m_data  <= w_avg;
         r_m_user  <= s_axis_tuser;
      end else if (m_axis_tready) begin
         r_m_valid <= 1'b0;
      end
   end

   assign m_axis_tvalid = r_m_valid;
   assign m_axis_tdata  = r_m_data;
   assign m_axis_tuser  = r_m_user;

endmodule

// File: tb/tb_demod_decim.sv
// Bench for demod_decim: directed tables, stall/reset sequences and random traffic
// scored against an arithmetic per-channel averaging model.
module tb_demod_decim;

   localparam int DL2 = 5;
   localparam int D   = 1 << DL2;

`ifdef DEMOD_DECIM_ROUND_EN
   localparam int EXP_SMALL_POS = 1;
   localparam int EXP_SMALL_NEG = 0;
`else
   localparam int EXP_SMALL_POS = 0;
   localparam int EXP_SMALL_NEG = -1;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [23:0] s_axis_tdata = '0;
   logic        s_axis_tvalid = 1'b0;
   logic        s_axis_tready;
   logic [1:0]  s_axis_tuser = '0;
   logic [23:0] m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready = 1'b1;
   logic [1:0]  m_axis_tuser;

   demod_decim #(.DECIM_LOG2(DL2)) dut (
      .s_axis_aclk    (clk),
      .s_axis_aresetn (rst_n),
      .s_axis_tdata   (s_axis_tdata),
      .s_axis_tvalid  (s_axis_tvalid),
      .s_axis_tready  (s_axis_tready),
      .s_axis_tuser   (s_axis_tuser),
      .m_axis_tdata   (m_axis_tdata),
      .m_axis_tvalid  (m_axis_tvalid),
      .m_axis_tready  (m_axis_tready),
      .m_axis_tuser   (m_axis_tuser)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] ch;
      int         data;
      int         exp;
   } vec_t;

   typedef struct {
      logic [1:0] ch;
      int         val;
   } out_t;

   out_t   exp_q[$];
   longint msum [4];
   int     mcnt [4];

   int         got_val [0:4095];
   logic [1:0] got_ch  [0:4095];
   int         got_wr = 0;
   int         got_rd = 0;

   int checks = 0;
   int errors = 0;
   bit rand_mode = 1'b0;

   // Inputs change only 1 time unit after posedge, so a handshake seen here completes at the next posedge.
   always @(negedge clk) begin
      if (rst_n && m_axis_tvalid && m_axis_tready && got_wr < 4096) begin
         got_val[got_wr] <= {{8{m_axis_tdata[23]}}, m_axis_tdata};
         got_ch[got_wr]  <= m_axis_tuser;
         got_wr          <= got_wr + 1;
      end
   end

   function automatic int model_avg(input longint s);
      longint t;
      longint q;
      t = s;
`ifdef DEMOD_DECIM_ROUND_EN
      t = t + D / 2;
`endif
      q = t / D;
      if ((t % D) != 0 && t < 0) q = q - 1;
      return int'(q);
   endfunction

   task automatic model_reset();
      for (int c = 0; c < 4; c++) begin
         msum[c] = 0;
         mcnt[c] = 0;
      end
      exp_q.delete();
   endtask

   task automatic model_accept(input logic [1:0] ch, input int d);
      out_t o;
      msum[ch] = msum[ch] + longint'(d);
      mcnt[ch] = mcnt[ch] + 1;
      if (mcnt[ch] == D) begin
         o.ch = ch;
         o.val = model_avg(msum[ch]);
         exp_q.push_back(o);
         msum[ch] = 0;
         mcnt[ch] = 0;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_int(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   task automatic send(input logic [1:0] ch, input int d);
      logic ok;
      int   guard;
      s_axis_tvalid = 1'b1;
      s_axis_tuser  = ch;
      s_axis_tdata  = d[23:0];
      ok    = 1'b0;
      guard = 0;
      while (!ok) begin
         if (rand_mode) m_axis_tready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         ok = s_axis_tready;
         tick();
         guard++;
         if (!ok && guard > 200) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: s_axis_tready stuck low, ch %0d", ch);
            break;
         end
      end
      if (ok) model_accept(ch, d);
      s_axis_tvalid = 1'b0;
   endtask

   task automatic score_outputs();
      out_t e;
      while (got_rd < got_wr) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL extra_output: ch %0d val %0d, nothing expected", got_ch[got_rd], got_val[got_rd]);
         end else begin
            e = exp_q.pop_front();
            if (got_val[got_rd] != e.val || got_ch[got_rd] != e.ch) begin
               errors++;
               $display("FAIL model_output: got ch %0d val %0d, expected ch %0d val %0d",
                        got_ch[got_rd], got_val[got_rd], e.ch, e.val);
            end
         end
         got_rd++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL missing_output: %0d outputs never appeared", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic drain();
      rand_mode     = 1'b0;
      m_axis_tready = 1'b1;
      s_axis_tvalid = 1'b0;
      repeat (4) tick();
      score_outputs();
   endtask

   task automatic check_last(input string name, input logic [1:0] ch, input int val);
      if (got_wr == 0) begin
         checks++;
         errors++;
         $display("FAIL %s: no output seen, expected %0d", name, val);
      end else begin
         check_int({name, "_val"}, got_val[got_wr-1], val);
         check_int({name, "_ch"}, int'(got_ch[got_wr-1]), int'(ch));
      end
   endtask

   vec_t ilv [4];
   vec_t seq [5];
   int   base;
   int   d;

   initial begin
      model_reset();
      ilv[0] = '{ch: 2'd0, data: 100,      exp: 100};
      ilv[1] = '{ch: 2'd1, data: -100,     exp: -100};
      ilv[2] = '{ch: 2'd2, data: 8388607,  exp: 8388607};
      ilv[3] = '{ch: 2'd3, data: -8388608, exp: -8388608};
      seq[0] = '{ch: 2'd1, data: -7,       exp: -7};
      seq[1] = '{ch: 2'd3, data: 12345,    exp: 12345};
      seq[2] = '{ch: 2'd2, data: -1,       exp: -1};
      seq[3] = '{ch: 2'd0, data: 0,        exp: 0};
      seq[4] = '{ch: 2'd1, data: -8388608, exp: -8388608};

      repeat (3) tick();
      check_int("rst_m_tvalid", int'(m_axis_tvalid), 0);
      check_int("rst_m_tdata", int'(m_axis_tdata), 0);
      check_int("rst_m_tuser", int'(m_axis_tuser), 0);
      check_int("rst_s_tready", int'(s_axis_tready), 1);
      rst_n = 1'b1;
      tick();

      // single channel, latency of the dump
      base = got_wr;
      for (int i = 0; i < D; i++) begin
         send(2'd0, 1000);
         if (i == D - 2) check_int("lat_before_last", int'(m_axis_tvalid), 0);
         if (i == D - 1) begin
            check_int("lat_valid_after_last", int'(m_axis_tvalid), 1);
            check_int("lat_data_after_last", int'(m_axis_tdata), 1000);
         end
      end
      drain();
      check_int("single_out_count", got_wr - base, 1);
      check_last("single", 2'd0, 1000);

      // interleaved channels, including full-scale extremes
      base = got_wr;
      for (int r = 0; r < D; r++)
         for (int k = 0; k < 4; k++) send(ilv[k].ch, ilv[k].data);
      drain();
      check_int("ilv_out_count", got_wr - base, 4);
      for (int k = 0; k < 4; k++) begin
         check_int("ilv_val", got_val[base + k], ilv[k].exp);
         check_int("ilv_ch", int'(got_ch[base + k]), int'(ilv[k].ch));
      end

      // constant bursts, one channel at a time
      for (int v = 0; v < 5; v++) begin
         for (int i = 0; i < D; i++) send(seq[v].ch, seq[v].data);
         drain();
         check_last("burst", seq[v].ch, seq[v].exp);
      end

      // rounding boundary: small positive and small negative sums
      for (int i = 0; i < D - 1; i++) send(2'd0, 0);
      send(2'd0, 16);
      drain();
      check_last("small_pos", 2'd0, EXP_SMALL_POS);
      send(2'd0, -1);
      for (int i = 0; i < D - 1; i++) send(2'd0, 0);
      drain();
      check_last("small_neg", 2'd0, EXP_SMALL_NEG);

      // downstream stall with a waiting input beat
      base = got_wr;
      for (int i = 0; i < D - 1; i++) send(2'd0, 7);
      m_axis_tready = 1'b0;
      send(2'd0, 7);
      s_axis_tvalid = 1'b1;
      s_axis_tuser  = 2'd0;
      s_axis_tdata  = 24'd3;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         check_int("stall_s_tready", int'(s_axis_tready), 0);
         check_int("stall_m_tdata", int'(m_axis_tdata), 7);
         check_int("stall_m_tvalid", int'(m_axis_tvalid), 1);
         tick();
      end
      m_axis_tready = 1'b1;
      for (int i = 0; i < D; i++) send(2'd0, 3);
      drain();
      check_int("stall_out_count", got_wr - base, 2);
      check_last("stall_next", 2'd0, 3);

      // reset with a partial sum on ch1 and a pending output on ch2
      for (int i = 0; i < 20; i++) send(2'd1, 77);
      m_axis_tready = 1'b0;
      for (int i = 0; i < D; i++) send(2'd2, 9);
      rst_n = 1'b0;
      #1;
      check_int("midrst_m_tvalid", int'(m_axis_tvalid), 0);
      check_int("midrst_m_tdata", int'(m_axis_tdata), 0);
      model_reset();
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      m_axis_tready = 1'b1;
      base = got_wr;
      for (int i = 0; i < D; i++) send(2'd1, 5);
      drain();
      check_int("postrst_out_count", got_wr - base, 1);
      check_last("postrst", 2'd1, 5);

      // random interleave, random data, random backpressure
      rand_mode = 1'b1;
      for (int n = 0; n < 1200; n++) begin
         if ($urandom_range(0, 7) == 0) begin
            m_axis_tready = ($urandom_range(0, 3) != 0);
            tick();
         end
         d = int'($urandom) >>> 8;
         send(2'($urandom_range(0, 3)), d);
      end
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
